// File: rtl/pixel_column_store_pkg.sv
// Shared definitions for the pixel column store: image geometry, colours,
// FSM state encoding and the column priority encoder.
package pixel_store_pkg;

  localparam int N      = 64;   // columns, power of 2
  localparam int ROWS   = 64;   // rows, power of 2
  localparam int SCALE  = 3;    // VGA pixels per cell side = 2**SCALE
  localparam int DATA_W = 8;    // pixel width
  localparam int CW     = $clog2(N);
  localparam int RW     = $clog2(ROWS);
  localparam int AW     = CW + RW;

  localparam logic [DATA_W-1:0] BG = 8'h00;

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, ACK} state_t;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [CW-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CW'(i);
    end
  endfunction

endpackage

// File: rtl/pixel_column_store_if.sv
// Per-column write handshake between the grid plotter (master) and the
// pixel column store (slave).
interface pixel_column_store_if;
  import pixel_store_pkg::*;

  logic [N-1:0]      col_select;
  logic [9:0]        row_select;
  logic [DATA_W-1:0] pixel_color;
  logic [N-1:0]      return_sig;

  modport master (
    output col_select,
    output row_select,
    output pixel_color,
    input  return_sig
  );

  modport slave (
    input  col_select,
    input  row_select,
    input  pixel_color,
    output return_sig
  );
endinterface

// File: rtl/pixel_column_store_ram.sv
// Simple dual-port image RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module pixel_ram_dp
  import pixel_store_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**AW];

  // Write port and registered read share one process so reads see pre-write contents.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end

endmodule

// File: rtl/pixel_column_store.sv
// Pixel image store: clears itself after reset or on request, accepts
// per-column pixel writes through the col_select/return_sig handshake and
// serves the VGA driver through a 2-cycle scaled read port.
module pixel_column_store
  import pixel_store_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  pixel_column_store_if.slave   px,
  input  logic                  clear_req,
  output logic                  clear_busy,
  input  logic [9:0]            vga_x,
  input  logic [9:0]            vga_y,
  output logic [DATA_W-1:0]     vga_color
);

  localparam logic [10:0] X_LIM   = 11'(N << SCALE);
  localparam logic [10:0] Y_LIM   = 11'(ROWS << SCALE);
  localparam logic [9:0]  ROW_LIM = 10'(ROWS);

  state_t            state, state_n;
  logic [AW-1:0]     clr_addr, clr_n;
  logic [N-1:0]      ret_q, ret_n;
  logic              clr_pend, pend_n;
  logic              latch;

  logic [CW-1:0]     col_p0;
  logic [9:0]        row_p0;
  logic [DATA_W-1:0] color_p0;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;

  logic              in_reg_p1, in_reg_p2;
  logic [AW-1:0]     raddr_p1;
  logic [DATA_W-1:0] q_p2;

  assign clear_busy    = (state == CLEAR);
  assign px.return_sig = ret_q;

  // Control state: FSM, clear counter, ack register and deferred clear flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      ret_q    <= '0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_n;
      ret_q    <= ret_n;
      clr_pend <= pend_n;
    end
  end

  // Next-state logic and the single RAM write port shared by clear and pixel writes.
  always_comb begin
    state_n = state;
    clr_n   = clr_addr;
    ret_n   = ret_q;
    pend_n  = clr_pend;
    latch   = 1'b0;
    we      = 1'b0;
    waddr   = clr_addr;
    wdata   = BG;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        clr_n = clr_addr + AW'(1);
        if (clr_addr == {AW{1'b1}}) state_n = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          state_n = CLEAR;
          clr_n   = '0;
        end else if (|px.col_select) begin
          latch   = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        // Out-of-range rows are acknowledged without touching the image.
        we          = (row_p0 < ROW_LIM);
        waddr       = {row_p0[RW-1:0], col_p0};
        wdata       = color_p0;
        ret_n       = '0;
        ret_n[col_p0] = 1'b1;
        if (clear_req) pend_n = 1'b1;
        state_n     = ACK;
      end
      ACK: begin
        if (clear_req) pend_n = 1'b1;
        if (!px.col_select[col_p0]) begin
          ret_n = '0;
          if (clr_pend || clear_req) begin
            state_n = CLEAR;
            clr_n   = '0;
            pend_n  = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // Request capture: winning column, row and colour held for the write.
  always_ff @(posedge clock) begin
    if (latch) begin
      col_p0   <= lowest_set(px.col_select);
      row_p0   <= px.row_select;
      color_p0 <= px.pixel_color;
    end
  end

  // ---- VGA stage 1: region test and scaled cell address ----
  // Region flag travels with the address through the read pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_reg_p1 <= 1'b0;
      in_reg_p2 <= 1'b0;
    end else begin
      in_reg_p1 <= ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
      in_reg_p2 <= in_reg_p1;
    end
  end

  // Cell address from truncated coordinate bits.
  always_ff @(posedge clock) begin
    raddr_p1 <= {vga_y[SCALE+RW-1:SCALE], vga_x[SCALE+CW-1:SCALE]};
  end

  // ---- VGA stage 2: registered RAM read, out-of-region fill ----
  pixel_ram_dp u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr_p1),
    .q     (q_p2)
  );

  assign vga_color = in_reg_p2 ? q_p2 : BG;

endmodule

// File: tb/tb_pixel_column_store.sv
// Bench for pixel_column_store: directed handshake/clear/reset scenarios plus
// randomized writes and VGA reads compared against an image array model.
module tb_pixel_column_store;
  import pixel_store_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear_req = 1'b0;
  logic              clear_busy;
  logic [9:0]        vga_x = '0;
  logic [9:0]        vga_y = '0;
  logic [7:0]        vga_color;

  int checks   = 0;
  int failures = 0;

  logic [7:0] img [ROWS][N];

  pixel_column_store_if px ();

  pixel_column_store dut (
    .clock      (clock),
    .reset      (reset),
    .px         (px.slave),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < N; c++)
        img[r][c] = BG;
  endtask

  function automatic logic [63:0] onehot(input int col);
    logic [63:0] v;
    v = '0;
    v[col] = 1'b1;
    return v;
  endfunction

  // Count edges until clear_busy drops; no ack may appear meanwhile.
  task automatic wait_sweep(input string tag);
    int cnt;
    int acks;
    cnt  = 0;
    acks = 0;
    while (clear_busy && cnt < 10000) begin
      if (px.return_sig != '0) acks++;
      tick();
      cnt++;
    end
    check_eq({tag, "_len"}, 64'(cnt), 64'd4096);
    check_eq({tag, "_noack"}, 64'(acks), 64'd0);
  endtask

  task automatic vga_check(input int x, input int y);
    logic [7:0] e;
    vga_x = 10'(x);
    vga_y = 10'(y);
    tick();
    tick();
    e = (x < (N << SCALE) && y < (ROWS << SCALE)) ? img[y >> SCALE][x >> SCALE] : BG;
    check_eq("vga", 64'(vga_color), 64'(e));
  endtask

  // Full single-column transaction from IDLE, holding the request `hold` extra cycles.
  task automatic do_write(input int col, input int row, input logic [7:0] color, input int hold);
    px.row_select  = 10'(row);
    px.pixel_color = color;
    px.col_select  = N'(onehot(col));
    tick();
    check_eq("ack_early", 64'(px.return_sig), 64'd0);
    tick();
    check_eq("ack_rise", 64'(px.return_sig), onehot(col));
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("ack_hold", 64'(px.return_sig), onehot(col));
    end
    px.col_select = '0;
    tick();
    check_eq("ack_drop", 64'(px.return_sig), 64'd0);
    if (row < ROWS) img[row][col] = color;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    px.col_select  = '0;
    px.row_select  = '0;
    px.pixel_color = '0;
    clear_model();

    // 1: reset values and initial sweep
    repeat (3) tick();
    check_eq("rst_ret", 64'(px.return_sig), 64'd0);
    check_eq("rst_busy", 64'(clear_busy), 64'd1);
    check_eq("rst_vga", 64'(vga_color), 64'(BG));
    reset = 1'b0;
    wait_sweep("init_sweep");
    vga_check(0, 0);
    vga_check(511, 511);

    // 2: single write with held ack
    do_write(5, 3, 8'hFF, 3);
    vga_check(40, 24);
    vga_check(48, 24);

    // 3: simultaneous requests, lowest index first
    px.row_select  = 10'd10;
    px.pixel_color = 8'h22;
    px.col_select  = N'(onehot(2) | onehot(9));
    tick();
    check_eq("pair_early", 64'(px.return_sig), 64'd0);
    tick();
    check_eq("pair_first", 64'(px.return_sig), onehot(2));
    px.col_select = N'(onehot(9));
    tick();
    check_eq("pair_drop2", 64'(px.return_sig), 64'd0);
    tick();
    check_eq("pair_wait9", 64'(px.return_sig), 64'd0);
    tick();
    check_eq("pair_second", 64'(px.return_sig), onehot(9));
    px.col_select = '0;
    tick();
    check_eq("pair_drop9", 64'(px.return_sig), 64'd0);
    img[10][2] = 8'h22;
    img[10][9] = 8'h22;
    vga_check(16, 80);
    vga_check(79, 87);

    // 4: out-of-range row is acked but not stored
    do_write(7, 100, 8'hAA, 0);
    for (int y = 0; y < 512; y += 73) vga_check(56, y);

    // randomized writes and reads against the model
    for (int i = 0; i < 40; i++) begin
      int col, row;
      col = int'($urandom_range(0, N - 1));
      row = ($urandom_range(0, 7) == 0) ? int'($urandom_range(64, 1023)) : int'($urandom_range(0, ROWS - 1));
      do_write(col, row, 8'($urandom), int'($urandom_range(0, 3)));
      if (i % 4 == 0) vga_check(col * 8 + int'($urandom_range(0, 7)), (row % ROWS) * 8);
    end
    for (int i = 0; i < 60; i++) vga_check(int'($urandom_range(0, 639)), int'($urandom_range(0, 639)));

    // 5: clear_req during ACK completes the ack first, then sweeps
    px.row_select  = 10'd4;
    px.pixel_color = 8'h5A;
    px.col_select  = N'(onehot(12));
    tick();
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_eq("clr_ack_held", 64'(px.return_sig), onehot(12));
    check_eq("clr_not_yet", 64'(clear_busy), 64'd0);
    px.col_select = '0;
    tick();
    check_eq("clr_ack_drop", 64'(px.return_sig), 64'd0);
    check_eq("clr_started", 64'(clear_busy), 64'd1);
    clear_model();
    px.row_select  = 10'd20;
    px.pixel_color = 8'h77;
    px.col_select  = N'(onehot(1));
    wait_sweep("req_sweep");
    tick();
    check_eq("post_clr_early", 64'(px.return_sig), 64'd0);
    tick();
    check_eq("post_clr_ack", 64'(px.return_sig), onehot(1));
    px.col_select = '0;
    tick();
    img[20][1] = 8'h77;
    vga_check(8, 160);
    vga_check(40, 24);
    for (int i = 0; i < 10; i++) vga_check(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));

    // 6: out-of-region read and reset during ACK
    vga_check(600, 0);
    vga_check(0, 600);
    px.row_select  = 10'd30;
    px.pixel_color = 8'h3C;
    px.col_select  = N'(onehot(3));
    tick();
    tick();
    check_eq("rst_ack_up", 64'(px.return_sig), onehot(3));
    reset = 1'b1;
    tick();
    check_eq("rst_ack_clr", 64'(px.return_sig), 64'd0);
    check_eq("rst_busy2", 64'(clear_busy), 64'd1);
    reset = 1'b0;
    clear_model();
    wait_sweep("rst_sweep");
    tick();
    check_eq("redrive_early", 64'(px.return_sig), 64'd0);
    tick();
    check_eq("redrive_ack", 64'(px.return_sig), onehot(3));
    px.col_select = '0;
    tick();
    img[30][3] = 8'h3C;
    vga_check(24, 240);
    vga_check(8, 160);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
